// File: rtl/issue_ctrl_pkg.sv
// Shared types for the dual-issue stage: instruction record, score board entry
// and register address.
package issue_ctrl_pkg;

  localparam int unsigned ISSUE_DEPTH = 8;
  localparam int unsigned POS_W       = 8;
  localparam int unsigned REG_W       = 5;

  typedef logic [REG_W-1:0] reg_addr_t;

  typedef struct packed {
    logic [POS_W-1:0] position;
  } sb_data_t;

  typedef struct packed {
    reg_addr_t   rs;
    reg_addr_t   rt;
    reg_addr_t   rd;
    logic        use_rs;
    logic        use_rt;
    logic        has_dest;
    logic [2:0]  latency;
    logic        is_mem;
    logic        is_branch;
    logic [63:0] payload;
  } issue_inst_t;

  // One-hot forwarding distance for a result that appears after `lat` cycles.
  function automatic logic [POS_W-1:0] lat_to_pos(logic [2:0] lat);
    return POS_W'(1) << lat;
  endfunction

endpackage

// File: rtl/issue_ctrl_if.sv
// Decode, score board and execute-side signals of the issue stage.
interface issue_ctrl_if import issue_ctrl_pkg::*; ();

  logic        [1:0] in_valid;
  issue_inst_t [1:0] in_inst;
  logic              in_ready;
  reg_addr_t   [3:0] sb_read_addr;
  sb_data_t    [3:0] sb_data;
  logic        [1:0] sb_write_ena;
  reg_addr_t   [1:0] sb_write_addr;
  sb_data_t    [1:0] sb_data_in;
  logic        [1:0] issue_valid;
  issue_inst_t [1:0] issue_inst;

  modport master (
    output in_valid, in_inst, sb_data,
    input  in_ready, sb_read_addr, sb_write_ena, sb_write_addr, sb_data_in,
    input  issue_valid, issue_inst
  );

  modport slave (
    input  in_valid, in_inst, sb_data,
    output in_ready, sb_read_addr, sb_write_ena, sb_write_addr, sb_data_in,
    output issue_valid, issue_inst
  );

endinterface

// File: rtl/issue_fifo.sv
// Two-in / two-out circular instruction buffer with an occupancy count.
module issue_fifo import issue_ctrl_pkg::*; #(
  parameter int unsigned DEPTH = ISSUE_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic [1:0]                   push_cnt,
  input  issue_inst_t [1:0]            push_data,
  input  logic [1:0]                   pop_cnt,
  output issue_inst_t [1:0]            head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  issue_inst_t     mem_q [DEPTH];
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_p1, wr_ptr_p1;
  logic [CntW-1:0] count_q;

  assign rd_ptr_p1 = rd_ptr_q + PtrW'(1);
  assign wr_ptr_p1 = wr_ptr_q + PtrW'(1);
  assign head[0]   = mem_q[rd_ptr_q];
  assign head[1]   = mem_q[rd_ptr_p1];
  assign count     = count_q;

  // Storage needs no reset: the count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push_cnt != 2'd0) mem_q[wr_ptr_q]  <= push_data[0];
    if (push_cnt == 2'd2) mem_q[wr_ptr_p1] <= push_data[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_q + PtrW'(pop_cnt);
      wr_ptr_q <= wr_ptr_q + PtrW'(push_cnt);
      count_q  <= count_q + CntW'(push_cnt) - CntW'(pop_cnt);
    end
  end

endmodule

// File: rtl/issue_ctrl.sv
// Dual-issue stage: buffers decoded instructions, checks operands against the
// score board and issues up to two per cycle into a registered output stage.
module issue_ctrl import issue_ctrl_pkg::*; #(
  parameter int unsigned DEPTH       = ISSUE_DEPTH,
  parameter int unsigned READY_SHIFT = 1
) (
  input logic         clk,
  input logic         rst_n,
  input logic         stall,
  input logic         flash,
  issue_ctrl_if.slave bus
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [CntW-1:0]   count;
  issue_inst_t [1:0] head;
  logic [1:0]        push_cnt, pop_cnt;
  logic              in_ready, h0_vld, h1_vld, h0_ok, h1_ok;
  logic              h0_dst_nz, raw, waw, pair_ok, iss0, iss1;
  logic [1:0]        issue_valid_q;
  issue_inst_t [1:0] issue_inst_q;

  function automatic logic src_ok(logic use_src, reg_addr_t addr, sb_data_t d);
    return !use_src || (addr == '0) || ((d.position >> READY_SHIFT) == '0);
  endfunction

  assign in_ready = (count <= CntW'(DEPTH - 2));
  assign push_cnt = (in_ready && !flash) ?
                    ({1'b0, bus.in_valid[0]} + {1'b0, &bus.in_valid}) : 2'd0;

  issue_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flash),
    .push_cnt  (push_cnt),
    .push_data (bus.in_inst),
    .pop_cnt   (pop_cnt),
    .head      (head),
    .count     (count)
  );

  assign bus.sb_read_addr = {head[1].rt, head[1].rs, head[0].rt, head[0].rs};

  assign h0_vld = (count != '0);
  assign h1_vld = (count >= CntW'(2));
  assign h0_ok  = src_ok(head[0].use_rs, head[0].rs, bus.sb_data[0]) &&
                  src_ok(head[0].use_rt, head[0].rt, bus.sb_data[1]);
  assign h1_ok  = src_ok(head[1].use_rs, head[1].rs, bus.sb_data[2]) &&
                  src_ok(head[1].use_rt, head[1].rt, bus.sb_data[3]);

  // Pair hazards; a zero H0 destination never conflicts.
  assign h0_dst_nz = (head[0].rd != '0);
  assign raw = h0_dst_nz && ((head[1].use_rs && (head[1].rs == head[0].rd)) ||
                             (head[1].use_rt && (head[1].rt == head[0].rd)));
  assign waw = h0_dst_nz && (head[1].rd == head[0].rd);
  assign pair_ok = !raw && !waw && !(head[0].is_mem && head[1].is_mem) && !head[1].is_branch;

  assign iss0    = h0_vld && h0_ok && !stall && !flash;
  assign iss1    = iss0 && h1_vld && h1_ok && pair_ok;
  assign pop_cnt = {1'b0, iss0} + {1'b0, iss1};

  assign bus.sb_write_ena  = {iss1 && head[1].has_dest && (head[1].rd != '0),
                              iss0 && head[0].has_dest && (head[0].rd != '0)};
  assign bus.sb_write_addr = {head[1].rd, head[0].rd};
  assign bus.sb_data_in    = {lat_to_pos(head[1].latency), lat_to_pos(head[0].latency)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_valid_q <= '0;
      issue_inst_q  <= '0;
    end else if (flash) begin
      issue_valid_q <= '0;
    end else if (!stall) begin
      issue_valid_q <= {iss1, iss0};
      issue_inst_q  <= head;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.issue_valid = issue_valid_q;
  assign bus.issue_inst  = issue_inst_q;

endmodule
